// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;
  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {RUN, MD_WAIT, HALT} ctrl_state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_bubble;
    logic md_start;
    logic md_result_valid;
    logic halt_ack;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_DEFAULT = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1,
                                         default: 1'b0};
  localparam ctrl_out_t CTRL_RESET   = '{if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                         ex_mem_bubble: 1'b1, default: 1'b0};

  function automatic logic load_use(input logic mem_read, input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] rs1,
                                    input logic [REG_ADDR_W-1:0] rs2);
    return mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction
endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline control outputs; master is the controller side.
interface pipeline_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [REG_ADDR_W-1:0] Rs1_IF_ID, Rs2_IF_ID, Rd_ID_EX;
  logic                  Mem_Read_ID_EX, Md_Op_ID_EX, Branch_Taken_EX, Halt_Req;
  logic                  PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush;
  logic                  EX_MEM_Bubble, Md_Start, Md_Result_Valid, Halt_Ack;
  logic [CNT_W-1:0]      Stall_Cnt, Flush_Cnt;

  modport master (
    input  Rs1_IF_ID, Rs2_IF_ID, Rd_ID_EX, Mem_Read_ID_EX, Md_Op_ID_EX, Branch_Taken_EX, Halt_Req,
    output PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush,
           EX_MEM_Bubble, Md_Start, Md_Result_Valid, Halt_Ack, Stall_Cnt, Flush_Cnt
  );

  modport slave (
    output Rs1_IF_ID, Rs2_IF_ID, Rd_ID_EX, Mem_Read_ID_EX, Md_Op_ID_EX, Branch_Taken_EX, Halt_Req,
    input  PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush,
           EX_MEM_Bubble, Md_Start, Md_Result_Valid, Halt_Ack, Stall_Cnt, Flush_Cnt
  );
endinterface

// File: rtl/pipeline_ctrl_perf_counter.sv
// Wrapping event counter with enable.
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb cnt_d = en ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller: load-use stalls, redirect flushes, MUL/DIV occupancy, debug halt.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  pipeline_ctrl_if.master   bus
);
  localparam logic [3:0] MD_INIT = 4'(MD_LAT - 2);

  ctrl_state_t state_q, state_d;
  logic [3:0]  md_cnt_q, md_cnt_d;
  ctrl_out_t   o;
  logic        lu, flush_en, stall_en;

  always_comb
    lu = load_use(bus.Mem_Read_ID_EX, bus.Rd_ID_EX, bus.Rs1_IF_ID, bus.Rs2_IF_ID);

  always_comb begin
    o        = CTRL_DEFAULT;
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    flush_en = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.Branch_Taken_EX) begin
          o.if_id_flush = 1'b1;
          o.id_ex_flush = 1'b1;
          flush_en      = 1'b1;
        end else if (bus.Md_Op_ID_EX) begin
          o.md_start      = 1'b1;
          o.pc_write      = 1'b0;
          o.if_id_write   = 1'b0;
          o.id_ex_write   = 1'b0;
          o.ex_mem_bubble = 1'b1;
          md_cnt_d        = MD_INIT;
          state_d         = MD_WAIT;
        end else if (lu) begin
          // Single bubble: the load is in MEM next cycle, so no state is needed.
          o.pc_write    = 1'b0;
          o.if_id_write = 1'b0;
          o.id_ex_flush = 1'b1;
        end else if (bus.Halt_Req) begin
          state_d = HALT;
        end
      end
      MD_WAIT: begin
        if (md_cnt_q == '0) begin
          o.md_result_valid = 1'b1;
          state_d           = bus.Halt_Req ? HALT : RUN;
        end else begin
          o.pc_write      = 1'b0;
          o.if_id_write   = 1'b0;
          o.id_ex_write   = 1'b0;
          o.ex_mem_bubble = 1'b1;
          md_cnt_d        = md_cnt_q - 1'b1;
        end
      end
      HALT: begin
        // The release cycle already advances normally with Halt_Ack low.
        if (bus.Halt_Req) begin
          o.halt_ack      = 1'b1;
          o.pc_write      = 1'b0;
          o.if_id_write   = 1'b0;
          o.id_ex_write   = 1'b0;
          o.ex_mem_bubble = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (!rst_n) begin
      o        = CTRL_RESET;
      flush_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end

  always_comb stall_en = rst_n && !o.pc_write;

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .en(stall_en), .cnt(bus.Stall_Cnt)
  );
  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .en(flush_en), .cnt(bus.Flush_Cnt)
  );

  assign bus.PC_Write        = o.pc_write;
  assign bus.IF_ID_Write     = o.if_id_write;
  assign bus.ID_EX_Write     = o.id_ex_write;
  assign bus.IF_ID_Flush     = o.if_id_flush;
  assign bus.ID_EX_Flush     = o.id_ex_flush;
  assign bus.EX_MEM_Bubble   = o.ex_mem_bubble;
  assign bus.Md_Start        = o.md_start;
  assign bus.Md_Result_Valid = o.md_result_valid;
  assign bus.Halt_Ack        = o.halt_ack;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: cycle model checked every negedge plus directed literal checks.
module tb_pipeline_ctrl;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pipeline_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: remaining MUL/DIV cycles (including the result cycle), halt flag, counts.
  int               m_md_left, n_md_left;
  bit               m_halted, n_halted;
  logic [CNT_W-1:0] m_stall, m_flush, n_stall, n_flush;

  // {pc, if_id_w, id_ex_w, if_id_f, id_ex_f, bubble, start, valid, ack}
  logic [8:0] exp_o, act_o;

  always @(negedge clk) begin
    logic lu;
    lu = bus.Mem_Read_ID_EX && bus.Rd_ID_EX != 0 &&
         (bus.Rd_ID_EX == bus.Rs1_IF_ID || bus.Rd_ID_EX == bus.Rs2_IF_ID);
    n_md_left = m_md_left; n_halted = m_halted; n_stall = m_stall; n_flush = m_flush;
    exp_o = 9'b111_000_000;
    if (!rst_n) begin
      exp_o = 9'b000_111_000;
      n_md_left = 0; n_halted = 0; n_stall = 0; n_flush = 0;
    end else if (m_md_left == 1) begin
      exp_o = 9'b111_000_010;
      n_md_left = 0;
      n_halted  = bus.Halt_Req;
    end else if (m_md_left > 1) begin
      exp_o = 9'b000_001_000;
      n_md_left = m_md_left - 1;
    end else if (m_halted) begin
      if (bus.Halt_Req) exp_o = 9'b000_001_001;
      else n_halted = 0;
    end else if (bus.Branch_Taken_EX) begin
      exp_o = 9'b111_110_000;
      n_flush = m_flush + 1;
    end else if (bus.Md_Op_ID_EX) begin
      exp_o = 9'b000_001_100;
      n_md_left = MD_LAT - 1;
    end else if (lu) begin
      exp_o = 9'b001_010_000;
    end else if (bus.Halt_Req) begin
      n_halted = 1;
    end
    if (rst_n && !exp_o[8]) n_stall = m_stall + 1;
    act_o = {bus.PC_Write, bus.IF_ID_Write, bus.ID_EX_Write, bus.IF_ID_Flush, bus.ID_EX_Flush,
             bus.EX_MEM_Bubble, bus.Md_Start, bus.Md_Result_Valid, bus.Halt_Ack};
    chk("model_ctrl", 64'(act_o), 64'(exp_o));
    chk("model_stall_cnt", 64'(bus.Stall_Cnt), 64'(m_stall));
    chk("model_flush_cnt", 64'(bus.Flush_Cnt), 64'(m_flush));
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_md_left <= 0; m_halted <= 0; m_stall <= '0; m_flush <= '0;
    end else begin
      m_md_left <= n_md_left; m_halted <= n_halted; m_stall <= n_stall; m_flush <= n_flush;
    end

  task automatic set_in(input int rs1, input int rs2, input int rd, input bit mr,
                        input bit md, input bit br, input bit hr);
    bus.Rs1_IF_ID = 5'(rs1); bus.Rs2_IF_ID = 5'(rs2); bus.Rd_ID_EX = 5'(rd);
    bus.Mem_Read_ID_EX = mr; bus.Md_Op_ID_EX = md; bus.Branch_Taken_EX = br; bus.Halt_Req = hr;
    #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("reset_pc_write", 64'(bus.PC_Write), 64'd0);
    chk("reset_if_id_flush", 64'(bus.IF_ID_Flush), 64'd1);
    chk("reset_bubble", 64'(bus.EX_MEM_Bubble), 64'd1);
    chk("reset_stall_cnt", 64'(bus.Stall_Cnt), 64'd0);
    rst_n = 1'b1;
    step();

    // load-use on rs2
    do_reset();
    set_in(1, 5, 5, 1, 0, 0, 0);
    chk("lu_pc_write", 64'(bus.PC_Write), 64'd0);
    chk("lu_id_ex_flush", 64'(bus.ID_EX_Flush), 64'd1);
    step();
    set_in(1, 5, 5, 0, 0, 0, 0);
    chk("lu_after_pc_write", 64'(bus.PC_Write), 64'd1);
    chk("lu_stall_cnt", 64'(bus.Stall_Cnt), 64'd1);

    // x0 destination never stalls
    do_reset();
    set_in(1, 0, 0, 1, 0, 0, 0);
    chk("x0_pc_write", 64'(bus.PC_Write), 64'd1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("x0_stall_cnt", 64'(bus.Stall_Cnt), 64'd0);

    // branch wins over load-use
    do_reset();
    set_in(7, 2, 7, 1, 0, 1, 0);
    chk("br_if_id_flush", 64'(bus.IF_ID_Flush), 64'd1);
    chk("br_pc_write", 64'(bus.PC_Write), 64'd1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("br_flush_cnt", 64'(bus.Flush_Cnt), 64'd1);
    chk("br_stall_cnt", 64'(bus.Stall_Cnt), 64'd0);

    // MUL/DIV: start at t, bubble t..t+2, result at t+3
    do_reset();
    set_in(0, 0, 0, 0, 1, 0, 0);
    chk("md_start_t", 64'(bus.Md_Start), 64'd1);
    step();
    chk("md_start_t1", 64'(bus.Md_Start), 64'd0);
    chk("md_bubble_t1", 64'(bus.EX_MEM_Bubble), 64'd1);
    step();
    chk("md_bubble_t2", 64'(bus.EX_MEM_Bubble), 64'd1);
    chk("md_valid_t2", 64'(bus.Md_Result_Valid), 64'd0);
    step();
    chk("md_valid_t3", 64'(bus.Md_Result_Valid), 64'd1);
    chk("md_bubble_t3", 64'(bus.EX_MEM_Bubble), 64'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("md_stall_cnt", 64'(bus.Stall_Cnt), 64'd3);

    // halt requested during MD_WAIT is taken after the result
    do_reset();
    set_in(0, 0, 0, 0, 1, 0, 0);
    step();
    set_in(0, 0, 0, 0, 1, 0, 1);
    chk("mdh_ack_wait", 64'(bus.Halt_Ack), 64'd0);
    step();
    step();
    chk("mdh_valid", 64'(bus.Md_Result_Valid), 64'd1);
    set_in(0, 0, 0, 0, 0, 0, 1);
    step();
    chk("mdh_ack", 64'(bus.Halt_Ack), 64'd1);
    chk("mdh_pc_write", 64'(bus.PC_Write), 64'd0);
    step();
    step();
    chk("mdh_ack_hold", 64'(bus.Halt_Ack), 64'd1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("mdh_ack_drop", 64'(bus.Halt_Ack), 64'd0);
    chk("mdh_release_pc", 64'(bus.PC_Write), 64'd1);
    step();
    chk("mdh_run_id_ex", 64'(bus.ID_EX_Write), 64'd1);

    // reset in the middle of MD_WAIT
    do_reset();
    set_in(0, 0, 0, 0, 1, 0, 0);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pc_write", 64'(bus.PC_Write), 64'd0);
    chk("rst_mid_id_ex_flush", 64'(bus.ID_EX_Flush), 64'd1);
    chk("rst_mid_md_start", 64'(bus.Md_Start), 64'd0);
    step();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("rst_mid_no_valid", 64'(bus.Md_Result_Valid), 64'd0);
      step();
    end
    chk("rst_mid_stall_cnt", 64'(bus.Stall_Cnt), 64'd0);
    chk("rst_mid_flush_cnt", 64'(bus.Flush_Cnt), 64'd0);

    // mixed traffic, checked by the model only
    for (int i = 0; i < 120; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It sits beside the forwarding unit and handles every hazard that forwarding cannot resolve:
- load-use stalls;
- taken-branch/jump flushes;
- multi-cycle MUL/DIV occupancy of EX;
- debug halt requests.

It drives the pipeline-register write enables and flushes, sequences the MUL/DIV unit, and keeps stall/flush performance counters.

## Interface
Parameters:
- MD_LAT, 4, cycles the MUL/DIV unit occupies EX (legal range 2..15)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  pipeline clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- Rs1_IF_ID  in  5  rs1 of the instruction in ID
- Rs2_IF_ID  in  5  rs2 of the instruction in ID
- Rd_ID_EX  in  5  rd of the instruction in EX
- Mem_Read_ID_EX  in  1  instruction in EX is a load
- Md_Op_ID_EX  in  1  instruction in EX is MUL/DIV
- Branch_Taken_EX  in  1  EX resolved a taken branch/jump (redirect)
- Halt_Req  in  1  debug halt request, level
- PC_Write  out  1  PC register enable
- IF_ID_Write  out  1  IF/ID register enable
- ID_EX_Write  out  1  ID/EX register enable
- IF_ID_Flush  out  1  clear IF/ID to NOP
- ID_EX_Flush  out  1  clear ID/EX to NOP
- EX_MEM_Bubble  out  1  load NOP into EX/MEM
- Md_Start  out  1  one-cycle start pulse to the MUL/DIV unit
- Md_Result_Valid  out  1  MUL/DIV result is valid in EX this cycle
- Halt_Ack  out  1  pipeline frozen in HALT
- Stall_Cnt  out  CNT_W  count of cycles with PC_Write=0
- Flush_Cnt  out  CNT_W  count of redirects

## Operation
- States (`ctrl_state_t`): RUN, MD_WAIT, HALT.
- A load-use hazard (`lu`) is true when Mem_Read_ID_EX=1, Rd_ID_EX≠0, and Rd_ID_EX equals Rs1_IF_ID or Rs2_IF_ID.
- Default outputs in every state: PC_Write, IF_ID_Write and ID_EX_Write are 1; all flushes, bubbles and pulses are 0.

RUN, evaluated in this priority order:
1. Branch_Taken_EX=1: IF_ID_Flush=1 and ID_EX_Flush=1. `lu` is ignored because ID is being flushed. Flush_Cnt increments.
2. Md_Op_ID_EX=1: Md_Start=1, PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1. Load md_cnt=MD_LAT-2 and go to MD_WAIT.
3. `lu`=1: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. This is a single bubble; there is no state change, because the load has left EX by the next cycle.
4. Halt_Req=1 with none of the above: go to HALT. This cycle itself still advances normally.

MD_WAIT:
- PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1. md_cnt decrements each cycle.
- When md_cnt=0: Md_Result_Valid=1, EX_MEM_Bubble=0, all write enables 1. Go to RUN, or to HALT if Halt_Req=1.
- Branch, `lu` and Halt_Req are not acted on in MD_WAIT.
  - By construction EX holds the MUL/DIV op, so branch and load-use cannot occur here.
  - A halt request is deferred to the exit cycle.

HALT:
- Halt_Ack=1; all write enables 0; EX_MEM_Bubble=1.
- Return to RUN on the first cycle with Halt_Req=0; Halt_Ack drops in that same cycle.

Counters:
- Stall_Cnt increments on every cycle with PC_Write=0 and rst_n=1.
- Both counters wrap modulo 2^CNT_W and carry no saturation flag.

## Timing
Reset:
- rst_n=0 asynchronously forces state=RUN, md_cnt=0, Stall_Cnt=0, Flush_Cnt=0.
- While rst_n=0, outputs are forced to: PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, EX_MEM_Bubble=1, Md_Start=0, Md_Result_Valid=0, Halt_Ack=0.
- Reset asserted mid-MD_WAIT or mid-HALT abandons the operation; no Md_Result_Valid is produced.

Output timing:
- All control outputs are combinational from state, md_cnt and the current-cycle inputs.
- State and counters are registered.

MUL/DIV latency:
- Md_Start appears in the cycle the op is first seen in EX.
- Md_Result_Valid appears exactly MD_LAT-1 cycles after Md_Start, so EX is occupied for MD_LAT cycles in total.
- PC_Write is low for MD_LAT-1 cycles.

Other latencies:
- Redirect costs 2 fetch slots and takes 0 stall cycles.
- A load-use hazard costs exactly 1 stall cycle.
- HALT is entered one cycle after Halt_Req is sampled in RUN.

## Structure
- Package `pipe_ctrl_pkg` holds `ctrl_state_t`, the REG_ADDR_W=5 constant and the NOP encoding constant shared with the pipeline registers.
- Sub-module `perf_counter` (CNT_W-wide, with enable and wrap, asynchronous active-low reset) is instantiated twice, once for Stall_Cnt and once for Flush_Cnt.

## Test plan
- **Load-use hazard:** Mem_Read_ID_EX=1, Rd_ID_EX=5, Rs2_IF_ID=5 for one cycle -> PC_Write=0, IF_ID_Write=0 and ID_EX_Flush=1 for exactly 1 cycle; Stall_Cnt=1.
- **x0 destination:** same stimulus with Rd_ID_EX=0 -> no stall; Stall_Cnt unchanged.
- **Branch beats load-use:** Branch_Taken_EX=1 together with a `lu` condition -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1; Flush_Cnt=1, Stall_Cnt=0.
- **MUL/DIV sequencing:** MD_LAT=4, Md_Op_ID_EX=1 at cycle t -> Md_Start only at t; EX_MEM_Bubble high t..t+2; Md_Result_Valid at t+3; Stall_Cnt=3.
- **Halt during MUL/DIV:** Halt_Req raised during MD_WAIT -> HALT entered after Md_Result_Valid, Halt_Ack=1 until Halt_Req=0, then RUN with write enables at 1.
- **Reset mid-operation:** rst_n pulsed low at t+1 of an MD_WAIT -> outputs take their reset values immediately; after release the state is RUN, counters are 0, and no Md_Result_Valid occurs.
